// File: rtl/demux_stream_sched_if.sv
// Handshake and data bundle for demux_stream_sched.
// master: upstream source plus downstream channel sinks; slave: the scheduler.
interface demux_stream_sched_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic                 en_i;
    logic [DATA_W-1:0]    data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [3:0]           ch_ready_i;
    logic [DATA_W-1:0]    data_o;
    logic [3:0]           valid_o;
    logic [1:0]           sel_o;
    logic                 busy_o;
    logic [4*CNT_W-1:0]   stat_o;

    modport master (
        output en_i, data_i, valid_i, ch_ready_i,
        input  ready_o, data_o, valid_o, sel_o, busy_o, stat_o
    );

    modport slave (
        input  en_i, data_i, valid_i, ch_ready_i,
        output ready_o, data_o, valid_o, sel_o, busy_o, stat_o
    );
endinterface

// File: rtl/demux_stream_sched.sv
// Burst scheduler for a 1-to-4 stream demultiplexer.
// One valid/ready input is dealt out in bursts of up to BURST_LEN beats to
// four channels, picked round-robin among ready channels. The output is a
// registered one-entry buffer, so data_o/valid_o come straight from flops.
// Optional per-channel dispatch counters: define DEMUX_SCHED_STATS_EN.
module demux_stream_sched #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    demux_stream_sched_if.slave bus
);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0] BURST_MAX = BEAT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        sel_q, sel_d;
    logic [BEAT_W-1:0] beats_q, beats_d;

    logic              full_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        dest_q;

    logic [1:0]        pick;
    logic              pick_ok;
    logic              ready;
    logic              in_xfer;
    logic              out_xfer;

    // Accept a beat only while granted, under the burst limit, and when the
    // buffer is empty or is being emptied this same cycle.
    assign ready    = (state_q == GRANT) && bus.en_i && (beats_q < BURST_MAX) &&
                      (!full_q || bus.ch_ready_i[dest_q]);
    assign in_xfer  = bus.valid_i && ready;
    assign out_xfer = full_q && bus.ch_ready_i[dest_q];

    assign bus.ready_o = ready;
    assign bus.data_o  = data_q;
    assign bus.valid_o = full_q ? (4'b0001 << dest_q) : 4'b0000;
    assign bus.sel_o   = sel_q;
    assign bus.busy_o  = (state_q != IDLE);

    // Round-robin pick: first ready channel after the last granted one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick    = 2'd0;
        pick_ok = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!pick_ok && bus.ch_ready_i[last_q + 2'(i)]) begin
                pick    = last_q + 2'(i);
                pick_ok = 1'b1;
            end
        end
    end

    // Next-state logic for the grant FSM and burst bookkeeping.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        beats_d = beats_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en_i && pick_ok) begin
                    sel_d   = pick;
                    last_d  = pick;
                    beats_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (in_xfer) begin
                    beats_d = beats_q + 1'b1;
                end
                // A stalled channel keeps the grant; only a full burst, a
                // disable, or the source going quiet mid-burst ends it.
                if ((beats_d == BURST_MAX) || !bus.en_i ||
                    (!bus.valid_i && (beats_q != '0))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!full_q || out_xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 2'b11;
            sel_q   <= 2'd0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            beats_q <= beats_d;
        end
    end

    // One-entry output buffer; a fill wins over a drain in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            // NOTE: the data register is reset too, because data_o must read zero while in reset.
            data_q <= '0;
            dest_q <= 2'd0;
        end else if (in_xfer) begin
            full_q <= 1'b1;
            data_q <= bus.data_i;
            dest_q <= sel_q;
        end else if (out_xfer) begin
            full_q <= 1'b0;
        end
    end

`ifdef DEMUX_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];

    // Saturating per-channel count of delivered beats.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else if (out_xfer && (cnt_q[dest_q] != {CNT_W{1'b1}})) begin
            cnt_q[dest_q] <= cnt_q[dest_q] + 1'b1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_stat
        assign bus.stat_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`else
    assign bus.stat_o = {4*CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_demux_stream_sched.sv
// Directed self-checking bench for demux_stream_sched.
// Inputs change 1 time unit after the rising edge; outputs are compared 1
// time unit later, well away from the next edge.
module tb_demux_stream_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DEMUX_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    demux_stream_sched_if #(.DATA_W(8), .CNT_W(8)) bus ();

    demux_stream_sched #(
        .DATA_W   (8),
        .BURST_LEN(4),
        .CNT_W    (8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset over two edges; returns at the start of the first IDLE cycle.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Streams continuously; with the channels in ch_rdy always ready each burst
    // takes 6 cycles: GRANT (empty), 3 more accepts, DRAIN, IDLE.
    // seq holds the granted channel of burst k in bits [2k+1:2k].
    task automatic run_bursts(input string tag, input int nb, input logic [7:0] v0,
                              input logic [15:0] seq);
        logic [7:0] src;
        src = v0;
        for (int c = 0; c <= 6 * nb; c++) begin
            int k;
            int p;
            logic [1:0] ch;
            logic [3:0] ev;
            logic       er;
            logic       eb;
            bus.data_i = src;
            #1;
            k  = (c == 0) ? 0 : (c - 1) / 6;
            p  = (c == 0) ? 5 : (c - 1) % 6;
            ch = seq[2*k +: 2];
            ev = (p >= 1 && p <= 4) ? (4'b0001 << ch) : 4'b0000;
            er = (p <= 3);
            eb = (p <= 4);
            check({tag, "_valid"}, 32'(bus.valid_o), 32'(ev));
            check({tag, "_ready"}, 32'(bus.ready_o), 32'(er));
            check({tag, "_busy"},  32'(bus.busy_o),  32'(eb));
            if (p <= 4) check({tag, "_sel"}, 32'(bus.sel_o), 32'(ch));
            if (p >= 1 && p <= 4) check({tag, "_data"}, 32'(bus.data_o), 32'(8'(v0 + 8'(4*k + p - 1))));
            if (er) src = src + 8'd1;
            step();
        end
    endtask

    initial begin
        bus.en_i       = 1'b1;
        bus.data_i     = 8'h00;
        bus.valid_i    = 1'b0;
        bus.ch_ready_i = 4'b0000;

        // Reset state
        #2;
        check("rst_data",  32'(bus.data_o),  32'h0);
        check("rst_valid", 32'(bus.valid_o), 32'h0);
        check("rst_sel",   32'(bus.sel_o),   32'h0);
        check("rst_ready", 32'(bus.ready_o), 32'h0);
        check("rst_busy",  32'(bus.busy_o),  32'h0);
        check("rst_stat",  32'(bus.stat_o),  32'h0);

        // 1: all channels ready, five bursts ch0,ch1,ch2,ch3,ch0
        do_reset();
        bus.ch_ready_i = 4'b1111;
        bus.valid_i    = 1'b1;
        run_bursts("rr4", 5, 8'h01, {6'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
        #1;
        check("rr4_stat", 32'(bus.stat_o), STATS ? 32'h04040408 : 32'h0);

        // 2: only ch1/ch3 ready, bursts alternate ch1,ch3,ch1
        do_reset();
        bus.ch_ready_i = 4'b1010;
        bus.valid_i    = 1'b1;
        run_bursts("alt", 3, 8'h40, {10'd0, 2'd1, 2'd3, 2'd1});
        #1;
        check("alt_stat", 32'(bus.stat_o), STATS ? 32'h04000800 : 32'h0);

        // 3: ch2 stalls for 3 cycles with the buffer full
        do_reset();
        bus.ch_ready_i = 4'b0100;
        bus.valid_i    = 1'b1;
        bus.data_i     = 8'hA0;
        #1; check("stall_c0_busy", 32'(bus.busy_o), 32'h0);
        step();
        #1; check("stall_c1_sel", 32'(bus.sel_o), 32'h2);
        check("stall_c1_ready", 32'(bus.ready_o), 32'h1);
        step();
        bus.data_i     = 8'hA1;
        bus.ch_ready_i = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 32'(bus.ready_o), 32'h0);
            check("stall_valid", 32'(bus.valid_o), 32'h4);
            check("stall_data",  32'(bus.data_o),  32'hA0);
            check("stall_busy",  32'(bus.busy_o),  32'h1);
            step();
        end
        bus.ch_ready_i = 4'b0100;
        #1; check("stall_resume_ready", 32'(bus.ready_o), 32'h1);
        check("stall_resume_data", 32'(bus.data_o), 32'hA0);
        step();
        bus.data_i = 8'hA2;
        #1; check("stall_b1", 32'(bus.data_o), 32'hA1);
        step();
        bus.data_i = 8'hA3;
        #1; check("stall_b2", 32'(bus.data_o), 32'hA2);
        check("stall_b2_ready", 32'(bus.ready_o), 32'h1);
        step();
        #1; check("stall_b3", 32'(bus.data_o), 32'hA3);
        check("stall_b3_valid", 32'(bus.valid_o), 32'h4);
        check("stall_drain_ready", 32'(bus.ready_o), 32'h0);
        step();
        #1; check("stall_end_valid", 32'(bus.valid_o), 32'h0);
        check("stall_end_busy", 32'(bus.busy_o), 32'h0);

        // 4: source goes quiet after 2 beats; next grant is ch1 with a fresh burst
        do_reset();
        bus.ch_ready_i = 4'b1111;
        bus.valid_i    = 1'b1;
        bus.data_i     = 8'h10;
        step();                                   // c0 IDLE -> GRANT ch0
        #1; check("short_c1_ready", 32'(bus.ready_o), 32'h1);
        step();
        bus.data_i = 8'h11;
        #1; check("short_c2_data", 32'(bus.data_o), 32'h10);
        step();
        bus.valid_i = 1'b0;
        #1; check("short_c3_data",  32'(bus.data_o),  32'h11);
        check("short_c3_valid", 32'(bus.valid_o), 32'h1);
        step();
        #1; check("short_c4_busy",  32'(bus.busy_o),  32'h1);
        check("short_c4_valid", 32'(bus.valid_o), 32'h0);
        check("short_c4_ready", 32'(bus.ready_o), 32'h0);
        step();
        #1; check("short_c5_busy", 32'(bus.busy_o), 32'h0);
        step();
        #1; check("short_c6_sel",   32'(bus.sel_o),   32'h1);
        check("short_c6_ready", 32'(bus.ready_o), 32'h1);
        check("short_c6_busy",  32'(bus.busy_o),  32'h1);
        step();
        #1; check("short_c7_busy", 32'(bus.busy_o), 32'h1);
        bus.valid_i = 1'b1;
        bus.data_i  = 8'h20;
        step();
        bus.data_i = 8'h21;
        #1; check("short_c8_valid", 32'(bus.valid_o), 32'h2);
        check("short_c8_data", 32'(bus.data_o), 32'h20);
        step();
        bus.data_i = 8'h22;
        #1; check("short_c9_data", 32'(bus.data_o), 32'h21);
        step();
        bus.data_i = 8'h23;
        #1; check("short_c10_ready", 32'(bus.ready_o), 32'h1);
        step();
        #1; check("short_c11_ready", 32'(bus.ready_o), 32'h0);
        check("short_c11_data", 32'(bus.data_o), 32'h23);
        step();
        #1; check("short_c12_busy", 32'(bus.busy_o), 32'h0);
        bus.data_i = 8'h30;
        step();
        #1; check("short_c13_sel", 32'(bus.sel_o), 32'h2);
        step();
        #1; check("short_c14_valid", 32'(bus.valid_o), 32'h4);
        check("short_c14_data", 32'(bus.data_o), 32'h30);

        // 5: asynchronous reset in mid-cycle with a full buffer
        #2;
        rst = 1'b1;
        #1;
        check("arst_data",  32'(bus.data_o),  32'h0);
        check("arst_valid", 32'(bus.valid_o), 32'h0);
        check("arst_sel",   32'(bus.sel_o),   32'h0);
        check("arst_ready", 32'(bus.ready_o), 32'h0);
        check("arst_busy",  32'(bus.busy_o),  32'h0);
        check("arst_stat",  32'(bus.stat_o),  32'h0);
        do_reset();
        #1; check("arst_c0_busy", 32'(bus.busy_o), 32'h0);
        step();
        #1; check("arst_c1_sel", 32'(bus.sel_o), 32'h0);
        check("arst_c1_busy", 32'(bus.busy_o), 32'h1);

        // 6: ch0 only, over 300 beats; counter saturates at 0xFF
        do_reset();
        bus.ch_ready_i = 4'b0001;
        bus.valid_i    = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.data_i = 8'(c);
            step();
        end
        #1; check("stat_mid", 32'(bus.stat_o), STATS ? 32'h00000042 : 32'h0);
        for (int c = 0; c < 360; c++) begin
            bus.data_i = 8'(c);
            step();
        end
        #1; check("stat_sat", 32'(bus.stat_o), STATS ? 32'h000000FF : 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
